codec_intf: RTL and testbench
=============================

# codec_intf

Serial audio front end between the 50 MHz system clock domain and the external stereo codec. It generates the codec's MCLK, SCL and LRCLK clocks and its active-low reset, deserializes the codec's SDout stream into parallel 16-bit left/right samples, and serializes parallel samples back onto SDin. It sits directly below the equalizer top level: `lft_in`/`rht_in`/`valid` feed the filter datapath (or a straight loopback), and the datapath drives `lft_out`/`rht_out`.

## Interface
- No parameters. Frame format is fixed at 16-bit samples, 16 SCL periods per channel half-frame.
- `clk  in  1` — 50 MHz system clock.
- `RST_n  in  1` — **Reset is asynchronous and active-low; one clock.**
- `MCLK  out  1` — codec master clock, clk/4 = 12.5 MHz.
- `SCL  out  1` — serial bit clock, clk/32 = 1.5625 MHz.
- `LRCLK  out  1` — frame clock, clk/1024 ≈ 48.83 kHz. Low selects left, high selects right.
- `RSTn  out  1` — codec reset, active-low.
- `SDin  out  1` — serial data to the codec (DAC path).
- `SDout  in  1` — serial data from the codec (ADC path).
- `lft_in  out  16` — last captured left sample, signed two's complement.
- `rht_in  out  16` — last captured right sample.
- `valid  out  1` — one-clk pulse when `lft_in`/`rht_in` update.
- `lft_out  in  16` — left sample to transmit.
- `rht_out  in  16` — right sample to transmit.

## Operation
- Free-running 10-bit counter `cnt`, incremented every clk, wraps 0x3FF→0x000. All clocks are counter bits, so every output is flop-driven and glitch-free:
  - `MCLK = cnt[1]`
  - `SCL = cnt[4]`
  - `LRCLK = cnt[9]`
- Async reset loads `cnt = 0x200`. During reset: LRCLK=1, SCL=0, MCLK=0, RSTn=0, SDin=0, lft_in=0, rht_in=0, valid=0, both shift registers=0, `primed`=0.
- Codec reset: RSTn stays 0 until the first wrap to 0x000 after reset release, then stays 1 until the next RST_n assertion.
- Receive:
  - 32-bit shift register. At each cycle with `cnt[4:0]==0x0F` (SCL rises next cycle), shift `SDout` in at the LSB.
  - Bits are MSB first and left-justified: 16 captures per half-frame. The left half occupies cnt 0x000–0x1FF, the right half 0x200–0x3FF.
  - On the edge ending `cnt==0x3F0`, load `lft_in = rx[31:16]` and `rht_in = rx[15:0]`, and assert `valid` for exactly that following cycle, but only if `primed`=1.
  - `primed` is set on the edge ending `cnt==0x3FF`. It suppresses the partial first frame after reset.
- Transmit:
  - 32-bit shift register. On the edge ending `cnt==0x3FF`, load `{lft_out, rht_out}`. Load takes priority over shift.
  - Otherwise, on the edge ending any cycle with `cnt[4:0]==0x1F` (SCL falling), shift left by one.
  - `SDin = tx[31]`. Each bit is stable for a full SCL period around the SCL rising edge.
- `lft_out`/`rht_out` are sampled only at the end-of-frame edge and may change freely at other times.

## Timing
- Let k be the cycle index after RST_n release; cycle 0 has cnt=0x200.
- RSTn rises in cycle 512.
- First `valid` pulse is in cycle 1521. The cnt=0x3F1 occurrence at k=497 is suppressed. After that, `valid` pulses every 1024 cycles.
- ADC latency: the last right bit is captured on the edge ending cnt 0x3EF; data plus `valid` appear 2 cycles later.
- DAC latency: the sample loaded at the end of frame N appears on SDin from cnt 0x000 of frame N+1. Left MSB is first; right LSB is last, during cnt 0x3E0–0x3FF.
- Loopback budget: the datapath has 14 clks from `valid` until the next load edge to drive `lft_out`/`rht_out`.
- Reset asserted mid-frame: all state returns to reset values immediately (async), and the partial frame is discarded. `valid` must not pulse for any frame that began before reset.

## Structure
- Shared package (`codec_pkg`) holds:
  - `CNT_W=10` and `CNT_RST=10'h200`
  - `RX_SAMPLE_PH=5'h0F` and `TX_SHIFT_PH=5'h1F`
  - `VALID_CNT=10'h3F0` and `LOAD_CNT=10'h3FF`
  - `SAMPLE_W=16`
- One natural sub-module, `codec_shreg`: a 32-bit shift register with load, shift enable and serial in/out, instantiated once for receive and once for transmit. Counter and control stay in `codec_intf`.

## Test plan
- Reset and clock checks:
  - Hold RST_n low for 5 clks → LRCLK=1, SCL=0, MCLK=0, RSTn=0, SDin=0, valid=0, lft_in=rht_in=0.
  - Release reset → MCLK period 4 clks, SCL period 32, LRCLK period 1024, RSTn high at k=512.
- Receive capture:
  - Drive SDout with model-serialized frames, left=16'hA5C3 and right=16'h7F01, sampled on SCL rise.
  - Required: first valid at k=1521 with lft_in=16'hA5C3, rht_in=16'h7F01, one cycle wide.
  - Required: no valid at k=497.
- Transmit:
  - Hold lft_out=16'h8001, rht_out=16'h1234.
  - Required: the bit stream on SDin, sampled on SCL rise in the following frame, decodes to 0x8001 then 0x1234.
  - Change the inputs mid-frame → the current frame is unaffected.
- Loopback: tie lft_out=lft_in and rht_out=rht_in, with an SDout model sending 0xFFFF/0x0000 then 0x0000/0xFFFF. Required: SDin reproduces each pair exactly one frame after its valid.
- Mid-frame reset: assert RST_n at cnt≈0x150 for 3 clks → counter returns to 0x200 and RSTn goes low. Required: the next valid is exactly 1521 cycles after release.
- Extremes: stream 16'h8000 and 16'h7FFF in both channels → the captured and transmitted values keep sign and magnitude exactly, with no bit slip over 10 consecutive frames.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared constants and types for the codec serial front end.
// Pure declarations: no latency, no backpressure.
package codec_pkg;

  localparam int CNT_W    = 10;
  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = 2 * SAMPLE_W;

  localparam logic [CNT_W-1:0] CNT_RST   = 10'h200;
  localparam logic [CNT_W-1:0] VALID_CNT = 10'h3F0;
  localparam logic [CNT_W-1:0] LOAD_CNT  = 10'h3FF;

  localparam logic [4:0] RX_SAMPLE_PH = 5'h0F;
  localparam logic [4:0] TX_SHIFT_PH  = 5'h1F;

  // HOLD keeps the codec in reset and the receiver unprimed until the first frame wrap
  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } link_st_t;

endpackage

// File: rtl/codec_if.sv
// Codec pins plus the parallel sample bus toward the equalizer datapath.
// Wires only: no latency, no backpressure.
interface codec_if;
  import codec_pkg::*;

  logic                MCLK;
  logic                SCL;
  logic                LRCLK;
  logic                RSTn;
  logic                SDin;
  logic                SDout;
  logic [SAMPLE_W-1:0] lft_in;
  logic [SAMPLE_W-1:0] rht_in;
  logic                valid;
  logic [SAMPLE_W-1:0] lft_out;
  logic [SAMPLE_W-1:0] rht_out;

  modport master (
    output MCLK, SCL, LRCLK, RSTn, SDin, lft_in, rht_in, valid,
    input  SDout, lft_out, rht_out
  );

  modport slave (
    input  MCLK, SCL, LRCLK, RSTn, SDin, lft_in, rht_in, valid,
    output SDout, lft_out, rht_out
  );

endinterface

// File: rtl/codec_shreg.sv
// 32-bit shift register, parallel load over MSB-first shift; serial out is q[31].
// One clk per load/shift, no backpressure.
module codec_shreg
  import codec_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld,
  input  logic [FRAME_W-1:0] ld_dat,
  input  logic               shift,
  input  logic               sin,
  output logic [FRAME_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_dat;
    end else if (shift) begin
      q <= {q[FRAME_W-2:0], sin};
    end
  end

endmodule

// File: rtl/codec_intf.sv
// Codec clock/reset generation, SDout deserializer and SDin serializer off one frame counter.
// ADC data + valid 2 clks after last right bit; DAC frame one frame after load; no backpressure.
module codec_intf
  import codec_pkg::*;
(
  input  logic    clk,
  input  logic    RST_n,
  codec_if.master bus
);

  logic [CNT_W-1:0]   cnt;
  link_st_t           state_q;
  link_st_t           state_d;
  logic               primed;
  logic               rx_shift;
  logic               tx_shift;
  logic               tx_load;
  logic [FRAME_W-1:0] rx_sr;
  logic [FRAME_W-1:0] tx_sr;
  logic [FRAME_W-1:0] tx_ld_dat;
  logic               tx_msb;
  logic [FRAME_W-2:0] tx_unused;
  logic [SAMPLE_W-1:0] lft_q;
  logic [SAMPLE_W-1:0] rht_q;
  logic               valid_q;

  // All codec clocks are counter bits, so they come straight off flops
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      cnt <= CNT_RST;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: if (cnt == LOAD_CNT) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
    endcase
  end

  // The first frame after reset starts mid-stream; priming on the wrap discards it
  assign primed = (state_q == ST_RUN);

  assign rx_shift  = (cnt[4:0] == RX_SAMPLE_PH);
  assign tx_shift  = (cnt[4:0] == TX_SHIFT_PH);
  assign tx_load   = (cnt == LOAD_CNT);
  assign tx_ld_dat = {bus.lft_out, bus.rht_out};

  codec_shreg u_rx (
    .clk    (clk),
    .rst_n  (RST_n),
    .ld     (1'b0),
    .ld_dat ({FRAME_W{1'b0}}),
    .shift  (rx_shift),
    .sin    (bus.SDout),
    .q      (rx_sr)
  );

  codec_shreg u_tx (
    .clk    (clk),
    .rst_n  (RST_n),
    .ld     (tx_load),
    .ld_dat (tx_ld_dat),
    .shift  (tx_shift),
    .sin    (1'b0),
    .q      (tx_sr)
  );

  assign {tx_msb, tx_unused} = tx_sr;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      lft_q   <= '0;
      rht_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if ((cnt == VALID_CNT) && primed) begin
        lft_q   <= rx_sr[FRAME_W-1:SAMPLE_W];
        rht_q   <= rx_sr[SAMPLE_W-1:0];
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.MCLK   = cnt[1];
  assign bus.SCL    = cnt[4];
  assign bus.LRCLK  = cnt[9];
  assign bus.RSTn   = primed;
  assign bus.SDin   = tx_msb;
  assign bus.lft_in = lft_q;
  assign bus.rht_in = rht_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_codec_intf.sv
// Directed bench for codec_intf: codec-side SDout model, SDin decoder, and
// receive/transmit scoreboards checked with immediate assertions.
module tb_codec_intf;
  import codec_pkg::*;

  logic clk   = 1'b0;
  logic RST_n = 1'b0;

  codec_if bus ();

  codec_intf dut (
    .clk   (clk),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  logic        loop   = 1'b0;
  logic [15:0] lo_drv = 16'h0;
  logic [15:0] ro_drv = 16'h0;

  // Loopback ties the datapath outputs straight to the captured samples
  assign bus.lft_out = loop ? bus.lft_in : lo_drv;
  assign bus.rht_out = loop ? bus.rht_in : ro_drv;

  int          nvec = 0;
  int          nfail = 0;
  int          k;
  int          first_valid_k;
  logic [9:0]  mc;
  logic        seen_wrap;
  logic        cur_ok;
  logic [31:0] rx_src;
  logic [31:0] cur_frame;
  logic [31:0] dec;
  logic [31:0] rx_q[$];
  logic [31:0] tx_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Everything the bench does for the cycle whose model counter value is mc
  task automatic cycle();
    int idx;
    logic [31:0] exp;
    mc = 10'((k + 512) % 1024);
    if (mc == 10'h000) seen_wrap = 1'b1;
    chk("clocks_rstn", {bus.MCLK, bus.SCL, bus.LRCLK, bus.RSTn}, {mc[1], mc[4], mc[9], seen_wrap});

    if (k == 497) chk("no_valid_k497", bus.valid, 1'b0);
    if (bus.valid === 1'b1) begin
      if (first_valid_k < 0) first_valid_k = k;
      if (rx_q.size() == 0) begin
        chk("unexpected_valid", bus.valid, 1'b0);
      end else begin
        exp = rx_q.pop_front();
        chk("rx_data", {bus.lft_in, bus.rht_in}, exp);
        chk("valid_phase", mc, 10'h3F1);
      end
    end
    if (mc == 10'h3F2 && cur_ok) chk("valid_missing", rx_q.size(), 0);

    if (mc[4:0] == 5'h10) dec = {dec[30:0], bus.SDin};
    if (mc == 10'h3F0 && tx_q.size() > 0) begin
      exp = tx_q.pop_front();
      chk("tx_frame", dec, exp);
    end

    if (mc == 10'h000) begin
      cur_frame = rx_src;
      cur_ok    = 1'b1;
      rx_q.push_back(rx_src);
    end
    idx = 31 - int'(mc[9:5]);
    bus.SDout = cur_frame[idx];

    if (mc == 10'h3FF) begin
      if (!loop) tx_q.push_back({lo_drv, ro_drv});
      else if (cur_ok) tx_q.push_back(cur_frame);
    end
  endtask

  task automatic step();
    @(negedge clk);
    k++;
    cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input logic [9:0] t);
    for (int i = 0; i < 1100; i++) begin
      if (mc == t) break;
      step();
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    RST_n = 1'b0;
    rx_q.delete();
    tx_q.delete();
    cur_ok    = 1'b0;
    seen_wrap = 1'b0;
    bus.SDout = 1'b0;
    #1;
    chk("async_reset", {bus.LRCLK, bus.SCL, bus.MCLK, bus.RSTn, bus.SDin, bus.valid, bus.lft_in, bus.rht_in},
        {1'b1, 5'b0, 32'h0});
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("reset_state", {bus.LRCLK, bus.SCL, bus.MCLK, bus.RSTn, bus.SDin, bus.valid, bus.lft_in, bus.rht_in},
          {1'b1, 5'b0, 32'h0});
    end
    RST_n         = 1'b1;
    k             = 0;
    first_valid_k = -1;
    cycle();
  endtask

  initial begin
    bus.SDout     = 1'b0;
    k             = 0;
    first_valid_k = -1;
    mc            = 10'h200;
    seen_wrap     = 1'b0;
    cur_ok        = 1'b0;
    cur_frame     = 32'h0;
    dec           = 32'h0;

    lo_drv = 16'h8001;
    ro_drv = 16'h1234;
    rx_src = {16'hA5C3, 16'h7F01};
    do_reset(5);

    run(1530);
    chk("first_valid_k", first_valid_k, 1521);

    // DAC inputs change mid-frame; the frame already loaded must go out untouched
    run_to(10'h100);
    lo_drv = 16'h5555;
    ro_drv = 16'hAAAA;
    run(2048);

    loop   = 1'b1;
    rx_src = {16'hFFFF, 16'h0000};
    run(1024);
    rx_src = {16'h0000, 16'hFFFF};
    run(3072);

    for (int f = 0; f < 10; f++) begin
      rx_src = f[0] ? {16'h7FFF, 16'h8000} : {16'h8000, 16'h7FFF};
      run(1024);
    end

    run_to(10'h150);
    do_reset(3);
    for (int i = 0; i < 1600 && first_valid_k < 0; i++) step();
    chk("valid_after_reset", first_valid_k, 1521);
    run(1100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
